// File: rtl/iq_freelist_ctrl_pkg.sv
// Shared core constants and state type for the issue-queue free-list controller.
package iq_freelist_ctrl_pkg;

  localparam int unsigned IQ_DEPTH          = 32;
  localparam int unsigned IQ_INDEX          = 5;
  localparam int unsigned IQ_DISPATCH_WIDTH = 4;
  localparam int unsigned IQ_ISSUE_WIDTH    = 4;
  localparam int unsigned IQ_ACNT_W         = $clog2(IQ_DISPATCH_WIDTH) + 1;

  typedef enum logic [0:0] {
    ST_READY  = 1'b0,
    ST_REINIT = 1'b1
  } fl_state_e;

endpackage

// File: rtl/iq_freelist_ctrl_if.sv
// Dispatch allocation, issue free and free-list RAM signals of the free-list controller.
interface iq_freelist_ctrl_if import iq_freelist_ctrl_pkg::*; ();

  logic                                           alloc_req_i;
  logic [IQ_ACNT_W-1:0]                           alloc_cnt_i;
  logic                                           alloc_grant_o;
  logic [IQ_DISPATCH_WIDTH-1:0][IQ_INDEX-1:0]     alloc_idx_o;

  logic [IQ_ISSUE_WIDTH-1:0]                      free_vld_i;
  logic [IQ_ISSUE_WIDTH-1:0][IQ_INDEX-1:0]        free_idx_i;

  logic [IQ_DISPATCH_WIDTH-1:0][IQ_INDEX-1:0]     ram_rd_addr_o;
  logic [IQ_DISPATCH_WIDTH-1:0][IQ_INDEX-1:0]     ram_rd_data_i;
  logic [IQ_ISSUE_WIDTH-1:0][IQ_INDEX-1:0]        ram_wr_addr_o;
  logic [IQ_ISSUE_WIDTH-1:0][IQ_INDEX-1:0]        ram_wr_data_o;
  logic [IQ_ISSUE_WIDTH-1:0]                      ram_we_o;

  // Controller side
  modport slave (
    input  alloc_req_i, alloc_cnt_i, free_vld_i, free_idx_i, ram_rd_data_i,
    output alloc_grant_o, alloc_idx_o, ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_we_o
  );

  // Dispatch / issue / RAM side
  modport master (
    output alloc_req_i, alloc_cnt_i, free_vld_i, free_idx_i, ram_rd_data_i,
    input  alloc_grant_o, alloc_idx_o, ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_we_o
  );

endinterface

// File: rtl/iq_free_compact.sv
// Packs the valid free lanes onto the lowest write ports, in lane order, starting at tail.
module iq_free_compact import iq_freelist_ctrl_pkg::*; #(
  parameter  int unsigned INDEX       = IQ_INDEX,
  parameter  int unsigned ISSUE_WIDTH = IQ_ISSUE_WIDTH,
  localparam int unsigned SEL_W       = $clog2(ISSUE_WIDTH),
  localparam int unsigned CNT_W       = SEL_W + 1
) (
  input  logic [ISSUE_WIDTH-1:0]            free_vld_i,
  input  logic [ISSUE_WIDTH-1:0][INDEX-1:0] free_idx_i,
  input  logic [INDEX-1:0]                  tail_i,
  output logic [ISSUE_WIDTH-1:0][INDEX-1:0] wr_addr_o,
  output logic [ISSUE_WIDTH-1:0][INDEX-1:0] wr_data_o,
  output logic [ISSUE_WIDTH-1:0]            we_o,
  output logic [CNT_W-1:0]                  free_cnt_o
);

  logic [CNT_W-1:0] pos;

  // Running prefix count selects the destination port of each valid lane
  always_comb begin
    wr_data_o = '0;
    pos       = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (free_vld_i[i]) begin
        wr_data_o[pos[SEL_W-1:0]] = free_idx_i[i];
        pos                       = pos + CNT_W'(1);
      end
    end
    free_cnt_o = pos;
  end

  // Port k writes slot tail+k and is enabled only below the popcount
  always_comb begin
    wr_addr_o = '0;
    we_o      = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      wr_addr_o[k] = tail_i + INDEX'(k);
      we_o[k]      = (CNT_W'(k) < pos);
    end
  end

endmodule

// File: rtl/iq_freelist_ctrl.sv
// Circular free list of issue-queue indices held in an external RAM, with flush re-initialisation walk.
module iq_freelist_ctrl import iq_freelist_ctrl_pkg::*; #(
  parameter int unsigned DEPTH          = IQ_DEPTH,
  parameter int unsigned INDEX          = IQ_INDEX,
  parameter int unsigned DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
  parameter int unsigned ISSUE_WIDTH    = IQ_ISSUE_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  iq_freelist_ctrl_if.slave  fl_if,
  output logic [INDEX:0]     free_cnt_o,
  output logic               ready_o
);

  localparam int unsigned CNT_W  = INDEX + 1;
  localparam int unsigned FCNT_W = $clog2(ISSUE_WIDTH) + 1;

  fl_state_e        state_q, state_d;
  logic [INDEX-1:0] head_q, head_d;
  logic [INDEX-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [INDEX-1:0] walk_q, walk_d;

  logic [ISSUE_WIDTH-1:0][INDEX-1:0] cmp_addr;
  logic [ISSUE_WIDTH-1:0][INDEX-1:0] cmp_data;
  logic [ISSUE_WIDTH-1:0]            cmp_we;
  logic [FCNT_W-1:0]                 cmp_cnt;
  logic                              alloc_fire;
  logic [CNT_W-1:0]                  alloc_amt;

  iq_free_compact #(
    .INDEX       (INDEX),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_compact (
    .free_vld_i (fl_if.free_vld_i),
    .free_idx_i (fl_if.free_idx_i),
    .tail_i     (tail_q),
    .wr_addr_o  (cmp_addr),
    .wr_data_o  (cmp_data),
    .we_o       (cmp_we),
    .free_cnt_o (cmp_cnt)
  );

  assign free_cnt_o = count_q;
  assign ready_o    = (state_q == ST_READY);

  // Allocation: read the next entries from head; grant ignores same-cycle frees
  always_comb begin
    fl_if.alloc_grant_o = (state_q == ST_READY) && !flush_i &&
                          (count_q >= CNT_W'(fl_if.alloc_cnt_i));
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      fl_if.ram_rd_addr_o[i] = head_q + INDEX'(i);
      fl_if.alloc_idx_o[i]   = fl_if.ram_rd_data_i[i];
    end
    alloc_fire = fl_if.alloc_req_i && fl_if.alloc_grant_o;
    alloc_amt  = alloc_fire ? CNT_W'(fl_if.alloc_cnt_i) : '0;
  end

  // Write ports: compacted frees in READY, identity walk in REINIT, silent on reset/flush
  always_comb begin
    fl_if.ram_wr_addr_o = '0;
    fl_if.ram_wr_data_o = '0;
    fl_if.ram_we_o      = '0;
    if (!reset && !flush_i) begin
      if (state_q == ST_READY) begin
        fl_if.ram_wr_addr_o = cmp_addr;
        fl_if.ram_wr_data_o = cmp_data;
        fl_if.ram_we_o      = cmp_we;
      end else begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          fl_if.ram_wr_addr_o[k] = walk_q + INDEX'(k);
          fl_if.ram_wr_data_o[k] = walk_q + INDEX'(k);
        end
        fl_if.ram_we_o = '1;
      end
    end
  end

  // Next-state: flush dominates, otherwise pointer/count update or walk progress
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    walk_d  = walk_q;
    if (flush_i) begin
      state_d = ST_REINIT;
      walk_d  = '0;
    end else begin
      case (state_q)
        ST_READY: begin
          head_d  = head_q + INDEX'(alloc_amt);
          tail_d  = tail_q + INDEX'(cmp_cnt);
          count_d = count_q - alloc_amt + CNT_W'(cmp_cnt);
        end
        ST_REINIT: begin
          walk_d = walk_q + INDEX'(ISSUE_WIDTH);
          if (walk_q == INDEX'(DEPTH - ISSUE_WIDTH)) begin
            state_d = ST_READY;
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_W'(DEPTH);
          end
        end
        default: state_d = ST_READY;
      endcase
    end
  end

  // State register; the RAM powers up as identity so reset skips the walk
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_READY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      walk_q  <= walk_d;
    end
  end

  // More free entries than the queue holds means a double free upstream
  cnt_le_depth: assert property (@(posedge clk) disable iff (reset) count_q <= CNT_W'(DEPTH));

endmodule
